seg7_bank: RTL and testbench
============================

# seg7_bank

Parametrised register bank that drives NDIGITS active-low seven-segment displays from the processor-side store bus. It adds three things to the simple per-digit register scheme: a global hex-decode mode, global blanking, and per-digit blinking driven by an internal timer. It also provides registered read-back of every register. It sits between the memory-mapped I/O decoder and the board HEX pins.

## Interface
Parameters:
- NDIGITS, 6: number of digits driven; legal range 1..7, because the blink mask is carried on the 7-bit Data bus.
- BLINK_DIV, 25000000: blink half-period in Clock cycles; minimum 2.
- AW, 4: address width; must satisfy 2^AW ≥ NDIGITS+2.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Data  in  7  write data.
- Addr  in  AW  register address.
- Sel  in  1  write strobe; a write occurs on a rising edge with Sel=1.
- Rd  in  1  read strobe.
- RdData  out  7  read-back data, registered.
- H  out  7*NDIGITS  segment outputs, active-low. Digit i occupies H[7i+6:7i]; bit order within a digit is g..a = bit6..bit0.

## Operation
- Register map:
  - Addresses 0..NDIGITS-1: DIGIT[i], 7 bits. Holds active-high segment pattern or hex nibble.
  - Address NDIGITS: CTRL. bit0 HEX, bit1 BLANK, bit2 BLINK_EN; bits 6:3 read as 0.
  - Address NDIGITS+1: MASK, blink mask. Bit i selects digit i; bits ≥ NDIGITS read as 0.
  - Other addresses: writes ignored, reads return 0.
- Digit pattern:
  - HEX=0: pattern = DIGIT[i].
  - HEX=1: pattern = font(DIGIT[i][3:0]); DIGIT[i][6:4] are ignored.
  - Font values: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71.
- Digit i is dark when BLANK=1, or when BLINK_EN=1 and MASK[i]=1 and phase=1.
- Pin value: H digit i = dark ? 7'h7F : ~pattern.
- Blink timer:
  - cnt counts 0..BLINK_DIV-1 and wraps. At wrap, phase toggles.
  - Any write to CTRL forces cnt=0 and phase=0 on the same edge.
  - The timer runs regardless of BLINK_EN.
- Read: on an edge with Rd=1, RdData is loaded with the addressed register's value. With Rd=0, RdData holds its previous value.
- Simultaneous read and write to the same address: RdData returns the pre-write value.
- Reset (Resetn=0 at an edge) takes priority over Sel and Rd. It sets:
  - DIGIT=0, CTRL=0, MASK=0, cnt=0, phase=0, RdData=0.
  - H=all ones (all segments off).
- Reset mid-blink or mid-write behaves the same: all state returns to reset values and the write is discarded.

## Timing
- A write at edge k updates the register at edge k; the change appears on H at edge k+1. H is an output register stage, so write-to-pin latency is 2 edges from the Sel sample.
- Phase changes reach H one edge after the toggle.
- Read latency is 1: RdData is valid after the edge that sampled Rd.
- Blink full period is 2*BLINK_DIV cycles, with the phase=0 half first after a reset or a CTRL write.
- There are no stalls; a write or read can be issued every cycle.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex font constant and the font() function;
  - CTRL bit-index constants (HEX=0, BLANK=1, BLINK_EN=2);
  - address offset helpers (CTRL_ADDR=NDIGITS, MASK_ADDR=NDIGITS+1).
- Sub-module blink_timer (parameter BLINK_DIV; inputs Clock, Resetn, restart; output phase) holds cnt and phase.
- The register file, output stage and read mux live in the top level, generated per digit.

## Test plan
- Reset values: hold Resetn=0 for 2 cycles → H all ones, RdData=0. Then read every address → all 0.
- Raw write: write 0x3F to address 2 with HEX=0 → H[20:14]=0x40 exactly 2 edges after the strobe; other digits stay 0x7F. Read address 2 → 0x3F.
- Hex mode: write CTRL=0x01 and DIGIT[0]=0x7A → H[6:0]=~0x77=0x08. Write DIGIT[0]=0x0F → 0x0E.
- Blink (BLINK_DIV=4): MASK=0x05, CTRL=0x04, all digits 0x7F.
  - Digits 0 and 2 alternate between 0x00 and 0x7F every 4 cycles, starting visible.
  - Digits 1, 3..5 stay 0x00.
  - Rewriting CTRL mid-phase restarts the visible half.
- BLANK and boundaries: CTRL=0x02 → all digits 0x7F regardless of contents.
  - A write to address NDIGITS+2 changes nothing and reads back 0.
  - Simultaneous Rd/Sel to address 1 returns the old value.
  - Asserting Resetn=0 during blink restores all reset values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment register bank: hex font, CTRL bit
// positions and register address helpers.
package seg7_pkg;

  localparam int CTRL_HEX      = 0;
  localparam int CTRL_BLANK    = 1;
  localparam int CTRL_BLINK_EN = 2;

  // Active-high g..a patterns; the leftmost entry is nibble F, the rightmost nibble 0.
  localparam logic [15:0][6:0] HEX_FONT = '{
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] font(input logic [3:0] nib);
    return HEX_FONT[nib];
  endfunction

  function automatic int ctrl_addr(input int ndigits);
    return ndigits;
  endfunction

  function automatic int mask_addr(input int ndigits);
    return ndigits + 1;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink timer: phase toggles every BLINK_DIV cycles; restart
// forces the visible (phase=0) half to begin again.
module blink_timer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic restart,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/seg7_bank.sv
// Memory-mapped bank of NDIGITS active-low seven-segment displays with hex
// decode, global blanking, per-digit blinking and registered read-back.
module seg7_bank
  import seg7_pkg::*;
#(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int AW        = 4
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [6:0]             Data,
  input  logic [AW-1:0]          Addr,
  input  logic                   Sel,
  input  logic                   Rd,
  output logic [6:0]             RdData,
  output logic [7*NDIGITS-1:0]   H
);

  localparam logic [AW-1:0] CTRL_A = AW'(ctrl_addr(NDIGITS));
  localparam logic [AW-1:0] MASK_A = AW'(mask_addr(NDIGITS));

  logic [7*NDIGITS-1:0] digit_all;
  logic [2:0]           ctrl_q;
  logic [NDIGITS-1:0]   mask_q;
  logic [6:0]           rd_data_q, rd_data_d;
  logic [7*NDIGITS-1:0] h_q, h_d;
  logic                 phase;
  logic                 ctrl_wr;

  assign ctrl_wr = Sel && (Addr == CTRL_A);

  blink_timer #(.BLINK_DIV(BLINK_DIV)) u_timer (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .restart (ctrl_wr),
    .phase   (phase)
  );

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : gen_digit
      logic [6:0] digit_q;
      logic [6:0] pattern;
      logic       dark;

      always_ff @(posedge Clock) begin
        if (!Resetn)
          digit_q <= '0;
        else if (Sel && (Addr == AW'(gi)))
          digit_q <= Data;
      end

      assign pattern = ctrl_q[CTRL_HEX] ? font(digit_q[3:0]) : digit_q;
      assign dark    = ctrl_q[CTRL_BLANK] |
                       (ctrl_q[CTRL_BLINK_EN] & mask_q[gi] & phase);

      assign digit_all[7*gi +: 7] = digit_q;
      assign h_d[7*gi +: 7]       = dark ? 7'h7F : ~pattern;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      ctrl_q <= '0;
      mask_q <= '0;
    end else if (Sel) begin
      if (Addr == CTRL_A) ctrl_q <= Data[2:0];
      if (Addr == MASK_A) mask_q <= Data[NDIGITS-1:0];
    end
  end

  // Unmapped addresses fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (Addr == AW'(i)) rd_data_d = digit_all[7*i +: 7];
    end
    if (Addr == CTRL_A) rd_data_d = {4'b0000, ctrl_q};
    if (Addr == MASK_A) rd_data_d = 7'(mask_q);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rd_data_q <= '0;
      h_q       <= '1;
    end else begin
      if (Rd) rd_data_q <= rd_data_d;
      h_q <= h_d;
    end
  end

  assign RdData = rd_data_q;
  assign H      = h_q;

endmodule

// File: tb/tb_seg7_bank.sv
// Directed bench for seg7_bank (6 digits, 4-cycle blink half-period).
module tb_seg7_bank;

  localparam int ND = 6;
  localparam int AW = 4;

  logic            Clock = 1'b0;
  logic            Resetn;
  logic [6:0]      Data;
  logic [AW-1:0]   Addr;
  logic            Sel;
  logic            Rd;
  logic [6:0]      RdData;
  logic [7*ND-1:0] H;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_bank #(.NDIGITS(ND), .BLINK_DIV(4), .AW(AW)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Data   (Data),
    .Addr   (Addr),
    .Sel    (Sel),
    .Rd     (Rd),
    .RdData (RdData),
    .H      (H)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [6:0] d);
    Addr = AW'(a);
    Data = d;
    Sel  = 1'b1;
    tick();
    Sel  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int a, input logic [6:0] exp);
    Addr = AW'(a);
    Rd   = 1'b1;
    tick();
    Rd   = 1'b0;
    check_eq(tag, 64'(RdData), 64'(exp));
  endtask

  // Build an H vector from one pin value per digit.
  function automatic logic [7*ND-1:0] hvec(input logic [6:0] d0, d1, d2, d3, d4, d5);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Blink expectation k edges after a CTRL write: visible for k=1..4, dark 5..8, ...
  function automatic logic [7*ND-1:0] blink_exp(input int k);
    logic [6:0] m;
    m = ((((k - 1) / 4) % 2) == 1) ? 7'h7F : 7'h00;
    return hvec(m, 7'h00, m, 7'h00, 7'h00, 7'h00);
  endfunction

  initial begin
    Resetn = 1'b0;
    Data   = '0;
    Addr   = '0;
    Sel    = 1'b0;
    Rd     = 1'b0;

    // Reset values
    tick();
    tick();
    check_eq("reset_H", 64'(H), 64'({7*ND{1'b1}}));
    check_eq("reset_rddata", 64'(RdData), 64'h0);
    Resetn = 1'b1;
    for (int a = 0; a < 16; a++) rd_check($sformatf("reset_read_a%0d", a), a, 7'h00);

    // Raw write, two-edge latency to pins
    wr(2, 7'h3F);
    check_eq("raw_H_edge1", 64'(H), 64'({7*ND{1'b1}}));
    tick();
    check_eq("raw_H_edge2", 64'(H), 64'(hvec(7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F)));
    rd_check("raw_read_a2", 2, 7'h3F);

    // Hex mode
    wr(ND, 7'h01);
    wr(0, 7'h7A);
    tick();
    check_eq("hex_A", 64'(H), 64'(hvec(7'h08, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h40)));
    wr(0, 7'h0F);
    tick();
    check_eq("hex_F", 64'(H[6:0]), 64'h0E);
    rd_check("hex_read_ctrl", ND, 7'h01);

    // Blink: all digits lit, digits 0 and 2 masked
    wr(ND, 7'h00);
    for (int i = 0; i < ND; i++) wr(i, 7'h7F);
    wr(ND + 1, 7'h05);
    wr(ND, 7'h04);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq($sformatf("blink_k%0d", k), 64'(H), 64'(blink_exp(k)));
    end
    wr(ND, 7'h04);
    check_eq("blink_restart_k0", 64'(H), 64'(blink_exp(7)));
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq($sformatf("blink_restart_k%0d", k), 64'(H), 64'(blink_exp(k)));
    end
    rd_check("blink_read_mask", ND + 1, 7'h05);

    // Blank and boundaries
    wr(ND, 7'h02);
    tick();
    check_eq("blank_H", 64'(H), 64'({7*ND{1'b1}}));
    wr(ND + 2, 7'h55);
    rd_check("unmapped_read", ND + 2, 7'h00);
    rd_check("unmapped_ctrl", ND, 7'h02);
    rd_check("unmapped_mask", ND + 1, 7'h05);
    wr(ND, 7'h00);
    tick();
    check_eq("unblank_H", 64'(H), 64'({7*ND{1'b0}}));

    Addr = AW'(1);
    Data = 7'h11;
    Sel  = 1'b1;
    Rd   = 1'b1;
    tick();
    Sel  = 1'b0;
    Rd   = 1'b0;
    check_eq("rw_same_old", 64'(RdData), 64'h7F);
    rd_check("rw_same_new", 1, 7'h11);

    // Reset during blink, with a write in flight
    wr(ND, 7'h04);
    tick();
    tick();
    tick();
    tick();
    tick();
    Resetn = 1'b0;
    Addr   = AW'(0);
    Data   = 7'h22;
    Sel    = 1'b1;
    tick();
    Sel    = 1'b0;
    check_eq("midreset_H", 64'(H), 64'({7*ND{1'b1}}));
    check_eq("midreset_rddata", 64'(RdData), 64'h0);
    Resetn = 1'b1;
    tick();
    check_eq("postreset_H", 64'(H), 64'({7*ND{1'b1}}));
    rd_check("postreset_digit0", 0, 7'h00);
    rd_check("postreset_digit1", 1, 7'h00);
    rd_check("postreset_ctrl", ND, 7'h00);
    rd_check("postreset_mask", ND + 1, 7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
